gpio_ctrl: RTL and testbench
============================

Name: gpio_ctrl

Overview:
- Memory-mapped bus slave that sits between the MIPS core's data bus and the 32-bit GPIO port block.
- Decodes word-addressed register accesses with a req/ack handshake and generates the GPIO write strobes and write data.
- Keeps shadow copies of the output and direction registers for readback.
- Adds per-pin edge-triggered interrupt detection with enable, edge-select and write-1-to-clear pending registers, plus a single interrupt output to the core.

Parameters:
- WIDTH, 32, GPIO pin count and bus data width.
- ADDR_W, 3, word-index address width (8 register slots).

Ports:
- i_Clk  input  1  system clock, all logic on rising edge
- i_rst  input  1  synchronous active-high reset
- i_Req  input  1  bus request, sampled in IDLE
- i_We  input  1  1 = write, 0 = read; qualifies i_Req
- i_Addr  input  ADDR_W  register word index
- i_WData  input  WIDTH  bus write data
- o_Ack  output  1  one-cycle transaction acknowledge
- o_RData  output  WIDTH  read data, valid only while o_Ack=1
- o_Irq  output  1  level interrupt = |(PEND & IEN)
- i_DIN  input  WIDTH  registered pin levels from GPIO port
- o_DD  output  WIDTH  write data to GPIO port
- o_WEO  output  1  GPIO output-register write strobe
- o_WER  output  1  GPIO direction-register write strobe

Behaviour:
- Reset is synchronous and active-high on i_Clk; clock port i_Clk, reset port i_rst. Reset has priority over all other activity.
- Reset values:
  - o_Ack=0, o_RData=0, o_DD=0, o_WEO=0, o_WER=0, o_Irq=0.
  - Shadow registers DOUT_S=0 and DIR_S=0.
  - IEN=0, IRISE=0, PEND=0, DIN_PREV=0, FSM=IDLE.
- Register map (word index):
  - 0 DATA_OUT (RW)
  - 1 DIR (RW; bit=1 means input, bit=0 means driven output, matching the GPIO port)
  - 2 DATA_IN (RO, returns i_DIN)
  - 3 IEN (RW)
  - 4 IRISE (RW; 1 = rising edge, 0 = falling edge)
  - 5 PEND (read; write-1-to-clear)
  - 6, 7 unmapped: reads return 0, writes ignored, still acknowledged.
- FSM states: IDLE and ACK.
  - IDLE, i_Req=1: latch i_We, i_Addr and i_WData; go to ACK.
  - ACK: assert o_Ack for exactly 1 cycle; i_Req is ignored; return to IDLE.
  - Throughput is at most one transaction per 2 cycles.
  - A held i_Req starts a new transaction in the IDLE cycle after ACK.
- Write timing, all in the ACK cycle:
  - DATA_OUT: o_DD=latched data and o_WEO=1; DOUT_S updates at the end of the cycle.
  - DIR: o_DD=latched data and o_WER=1; DIR_S updates at the end of the cycle.
  - o_WEO and o_WER are never asserted together and are 0 outside ACK.
  - o_DD holds its last value when no strobe is asserted.
- Read timing: o_RData is registered and presented in the ACK cycle, 0 outside ACK. A DATA_IN read returns i_DIN as sampled in the capture (IDLE) cycle.
- Edge detection, every cycle:
  - DIN_PREV <= i_DIN.
  - rise = i_DIN & ~DIN_PREV; fall = ~i_DIN & DIN_PREV.
  - evt = DIR_S & IEN & (IRISE ? rise : fall), per bit.
  - Output pins (DIR_S bit=0) never set PEND.
- PEND update: PEND <= (PEND & ~clr) | evt, where clr = latched data during a PEND write in the ACK cycle, else 0. A new event in the same cycle as its clear leaves the bit set (set wins).
- Clearing IEN bits does not clear PEND, but masks the bit from o_Irq.
- o_Irq is registered: asserted the cycle after PEND&IEN becomes non-zero, deasserted the cycle after it becomes zero.
- Reset mid-transaction aborts it: no o_Ack, no strobe, FSM returns to IDLE.

Test Plan:
1. Reset, then write DIR=0x0000_00FF -> in ACK cycle o_WER=1, o_DD=0x0000_00FF, o_WEO=0, o_Ack=1; read DIR returns 0x0000_00FF.
2. Write DATA_OUT=0xA5A5_0000, then read it back -> o_WEO pulse with o_DD=0xA5A5_0000; read o_RData=0xA5A5_0000; read of index 6 returns 0 with o_Ack.
3. DIR=0x1, IEN=0x1, IRISE=0x1; drive i_DIN[0] 0->1 -> PEND=0x1 and o_Irq=1 one cycle later; a falling edge causes no change.
4. Write PEND=0x1 in the same cycle as a new rising edge on bit 0 -> PEND stays 0x1. Repeat with no edge -> PEND=0 and o_Irq drops the following cycle.
5. DIR=0 (all outputs), IEN=0xFFFF_FFFF; toggle i_DIN -> PEND remains 0, o_Irq=0.
6. Hold i_Req=1 for 6 cycles with a write -> exactly 3 o_Ack pulses on alternate cycles. Assert i_rst in a capture cycle -> no o_Ack and no strobe, all registers return to reset values.

Source files
------------

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: bus slave between the core data bus and the 32-bit GPIO port.
// Decodes word-indexed register accesses with a two-state req/ack handshake,
// drives the GPIO port write strobes, keeps readback shadows of the output and
// direction registers, and adds per-pin edge interrupts with a level o_Irq.
module gpio_ctrl #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 3
) (
  input  logic              i_Clk,
  input  logic              i_rst,
  input  logic              i_Req,
  input  logic              i_We,
  input  logic [ADDR_W-1:0] i_Addr,
  input  logic [WIDTH-1:0]  i_WData,
  output logic              o_Ack,
  output logic [WIDTH-1:0]  o_RData,
  output logic              o_Irq,
  input  logic [WIDTH-1:0]  i_DIN,
  output logic [WIDTH-1:0]  o_DD,
  output logic              o_WEO,
  output logic              o_WER
);

  // Register word indices; slots 6 and 7 are unmapped.
  localparam logic [ADDR_W-1:0] A_DOUT  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_DIR   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_DIN   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_IEN   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_IRISE = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_PEND  = ADDR_W'(5);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  state_t            r_State;
  state_t            w_NextState;
  logic              w_Capture;
  logic              w_InAck;

  // Transaction latched in the capture cycle, consumed in the ACK cycle.
  logic              r_We;
  logic [ADDR_W-1:0] r_Addr;
  logic [WIDTH-1:0]  r_WData;

  logic [WIDTH-1:0]  r_RData;
  logic [WIDTH-1:0]  r_DD;
  logic [WIDTH-1:0]  r_DoutS;
  logic [WIDTH-1:0]  r_DirS;
  logic [WIDTH-1:0]  r_Ien;
  logic [WIDTH-1:0]  r_Irise;
  logic [WIDTH-1:0]  r_Pend;
  logic [WIDTH-1:0]  r_DinPrev;
  logic              r_Irq;

  logic [WIDTH-1:0]  w_RdMux;
  logic [WIDTH-1:0]  w_Rise;
  logic [WIDTH-1:0]  w_Fall;
  logic [WIDTH-1:0]  w_Evt;
  logic [WIDTH-1:0]  w_Clr;
  logic              w_WrDout;
  logic              w_WrDir;
  logic              w_WrIen;
  logic              w_WrIrise;
  logic              w_WrPend;

  // Handshake state register; reset aborts any transaction in flight.
  always_ff @(posedge i_Clk) begin
    if (i_rst) begin
      r_State <= ST_IDLE;
    end else begin
      r_State <= w_NextState;
    end
  end

  // Next-state logic: IDLE captures a request, ACK always lasts one cycle.
  always_comb begin
    w_NextState = r_State;
    w_Capture   = 1'b0;
    case (r_State)
      ST_IDLE: begin
        if (i_Req) begin
          w_Capture   = 1'b1;
          w_NextState = ST_ACK;
        end
      end
      ST_ACK: begin
        w_NextState = ST_IDLE;
      end
      default: begin
        w_NextState = ST_IDLE;
      end
    endcase
  end

  assign w_InAck = (r_State == ST_ACK);

  // Write commits happen in the ACK cycle using the latched transaction.
  always_comb begin
    w_WrDout  = 1'b0;
    w_WrDir   = 1'b0;
    w_WrIen   = 1'b0;
    w_WrIrise = 1'b0;
    w_WrPend  = 1'b0;
    if (w_InAck && r_We) begin
      case (r_Addr)
        A_DOUT:  w_WrDout  = 1'b1;
        A_DIR:   w_WrDir   = 1'b1;
        A_IEN:   w_WrIen   = 1'b1;
        A_IRISE: w_WrIrise = 1'b1;
        A_PEND:  w_WrPend  = 1'b1;
        default: begin
        end
      endcase
    end
  end

  // Readback mux evaluated at capture time so DATA_IN reflects that cycle.
  always_comb begin
    w_RdMux = '0;
    case (i_Addr)
      A_DOUT:  w_RdMux = r_DoutS;
      A_DIR:   w_RdMux = r_DirS;
      A_DIN:   w_RdMux = i_DIN;
      A_IEN:   w_RdMux = r_Ien;
      A_IRISE: w_RdMux = r_Irise;
      A_PEND:  w_RdMux = r_Pend;
      default: w_RdMux = '0;
    endcase
  end

  // Latch the request fields when a transaction is accepted.
  always_ff @(posedge i_Clk) begin
    if (i_rst) begin
      r_We    <= 1'b0;
      r_Addr  <= '0;
      r_WData <= '0;
    end else if (w_Capture) begin
      r_We    <= i_We;
      r_Addr  <= i_Addr;
      r_WData <= i_WData;
    end
  end

  // Read data is loaded only for an accepted read, so it is zero outside ACK.
  always_ff @(posedge i_Clk) begin
    if (i_rst) begin
      r_RData <= '0;
    end else if (w_Capture && !i_We) begin
      r_RData <= w_RdMux;
    end else begin
      r_RData <= '0;
    end
  end

  // Port write data is loaded for port writes and otherwise holds its value.
  always_ff @(posedge i_Clk) begin
    if (i_rst) begin
      r_DD <= '0;
    end else if (w_Capture && i_We && ((i_Addr == A_DOUT) || (i_Addr == A_DIR))) begin
      r_DD <= i_WData;
    end
  end

  // Shadow and interrupt configuration registers update at the end of ACK.
  always_ff @(posedge i_Clk) begin
    if (i_rst) begin
      r_DoutS <= '0;
      r_DirS  <= '0;
      r_Ien   <= '0;
      r_Irise <= '0;
    end else begin
      if (w_WrDout) begin
        r_DoutS <= r_WData;
      end
      if (w_WrDir) begin
        r_DirS <= r_WData;
      end
      if (w_WrIen) begin
        r_Ien <= r_WData;
      end
      if (w_WrIrise) begin
        r_Irise <= r_WData;
      end
    end
  end

  // Edge events only on enabled input pins; driven outputs never raise PEND.
  assign w_Rise = i_DIN & ~r_DinPrev;
  assign w_Fall = ~i_DIN & r_DinPrev;
  assign w_Evt  = r_DirS & r_Ien & ((r_Irise & w_Rise) | (~r_Irise & w_Fall));
  assign w_Clr  = w_WrPend ? r_WData : '0;

  // Pending bits: write-1-to-clear, with a same-cycle event taking priority.
  always_ff @(posedge i_Clk) begin
    if (i_rst) begin
      r_DinPrev <= '0;
      r_Pend    <= '0;
    end else begin
      r_DinPrev <= i_DIN;
      r_Pend    <= (r_Pend & ~w_Clr) | w_Evt;
    end
  end

  // Interrupt line follows the enabled pending bits one cycle later.
  always_ff @(posedge i_Clk) begin
    if (i_rst) begin
      r_Irq <= 1'b0;
    end else begin
      r_Irq <= |(r_Pend & r_Ien);
    end
  end

  assign o_Ack   = w_InAck;
  assign o_RData = r_RData;
  assign o_DD    = r_DD;
  assign o_WEO   = w_WrDout;
  assign o_WER   = w_WrDir;
  assign o_Irq   = r_Irq;

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed scenarios for the GPIO bus slave with hand-computed
// expected values; each scenario task checks its own observations.
module tb_gpio_ctrl;

  logic        i_Clk;
  logic        i_rst;
  logic        i_Req;
  logic        i_We;
  logic [2:0]  i_Addr;
  logic [31:0] i_WData;
  logic        o_Ack;
  logic [31:0] o_RData;
  logic        o_Irq;
  logic [31:0] i_DIN;
  logic [31:0] o_DD;
  logic        o_WEO;
  logic        o_WER;

  int total = 0;
  int bad   = 0;

  logic        tAck;
  logic        tWeo;
  logic        tWer;
  logic [31:0] tRd;
  logic [31:0] tDd;

  gpio_ctrl #(.WIDTH(32), .ADDR_W(3)) dut (
    .i_Clk   (i_Clk),
    .i_rst   (i_rst),
    .i_Req   (i_Req),
    .i_We    (i_We),
    .i_Addr  (i_Addr),
    .i_WData (i_WData),
    .o_Ack   (o_Ack),
    .o_RData (o_RData),
    .o_Irq   (o_Irq),
    .i_DIN   (i_DIN),
    .o_DD    (o_DD),
    .o_WEO   (o_WEO),
    .o_WER   (o_WER)
  );

  // 10 ns clock
  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  // Absolute time limit so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One bus transaction: request at negedge, sample the ACK cycle 1 ns after
  // the capture edge, apply dinAck to the pins during ACK, return in IDLE.
  task automatic bus_xfer(input logic we, input logic [2:0] addr,
                          input logic [31:0] wdata, input logic [31:0] dinAck,
                          output logic ack, output logic [31:0] rdata,
                          output logic weo, output logic wer,
                          output logic [31:0] dd);
    @(negedge i_Clk);
    i_Req   = 1'b1;
    i_We    = we;
    i_Addr  = addr;
    i_WData = wdata;
    @(posedge i_Clk);
    #1;
    i_Req = 1'b0;
    i_DIN = dinAck;
    ack   = o_Ack;
    rdata = o_RData;
    weo   = o_WEO;
    wer   = o_WER;
    dd    = o_DD;
    @(posedge i_Clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_Clk);
    #1;
    total++; if (o_Ack !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack: got %b want 0", o_Ack); end
    total++; if (o_RData !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 0", o_RData); end
    total++; if (o_DD !== 32'h0) begin bad++; $display("[TB] FAIL reset_dd: got %h want 0", o_DD); end
    total++; if ({o_WEO, o_WER} !== 2'b00) begin bad++; $display("[TB] FAIL reset_strobes: got %b want 00", {o_WEO, o_WER}); end
    total++; if (o_Irq !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq: got %b want 0", o_Irq); end
    @(negedge i_Clk);
    i_rst = 1'b0;
    bus_xfer(1'b0, 3'd5, 32'h0, i_DIN, tAck, tRd, tWeo, tWer, tDd);
    total++; if (tRd !== 32'h0) begin bad++; $display("[TB] FAIL reset_pend_read: got %h want 0", tRd); end
  endtask

  task automatic test_dir_write();
    bus_xfer(1'b1, 3'd1, 32'h0000_00FF, i_DIN, tAck, tRd, tWeo, tWer, tDd);
    total++; if (tAck !== 1'b1) begin bad++; $display("[TB] FAIL dir_ack: got %b want 1", tAck); end
    total++; if (tWer !== 1'b1) begin bad++; $display("[TB] FAIL dir_wer: got %b want 1", tWer); end
    total++; if (tWeo !== 1'b0) begin bad++; $display("[TB] FAIL dir_weo: got %b want 0", tWeo); end
    total++; if (tDd !== 32'h0000_00FF) begin bad++; $display("[TB] FAIL dir_dd: got %h want 000000ff", tDd); end
    total++; if ({o_WEO, o_WER, o_Ack} !== 3'b000) begin bad++; $display("[TB] FAIL dir_after_idle: got %b want 000", {o_WEO, o_WER, o_Ack}); end
    bus_xfer(1'b0, 3'd1, 32'h0, i_DIN, tAck, tRd, tWeo, tWer, tDd);
    total++; if (tRd !== 32'h0000_00FF) begin bad++; $display("[TB] FAIL dir_read: got %h want 000000ff", tRd); end
    total++; if (tWer !== 1'b0) begin bad++; $display("[TB] FAIL dir_read_wer: got %b want 0", tWer); end
  endtask

  task automatic test_data_out();
    bus_xfer(1'b1, 3'd0, 32'hA5A5_0000, i_DIN, tAck, tRd, tWeo, tWer, tDd);
    total++; if ({tAck, tWeo, tWer} !== 3'b110) begin bad++; $display("[TB] FAIL dout_strobes: got %b want 110", {tAck, tWeo, tWer}); end
    total++; if (tDd !== 32'hA5A5_0000) begin bad++; $display("[TB] FAIL dout_dd: got %h want a5a50000", tDd); end
    bus_xfer(1'b0, 3'd0, 32'h0, i_DIN, tAck, tRd, tWeo, tWer, tDd);
    total++; if (tRd !== 32'hA5A5_0000) begin bad++; $display("[TB] FAIL dout_read: got %h want a5a50000", tRd); end
    total++; if (tDd !== 32'hA5A5_0000) begin bad++; $display("[TB] FAIL dd_hold: got %h want a5a50000", tDd); end
    total++; if (o_RData !== 32'h0) begin bad++; $display("[TB] FAIL rdata_outside_ack: got %h want 0", o_RData); end
    bus_xfer(1'b1, 3'd7, 32'hDEAD_BEEF, i_DIN, tAck, tRd, tWeo, tWer, tDd);
    total++; if ({tAck, tWeo, tWer} !== 3'b100) begin bad++; $display("[TB] FAIL unmapped_write: got %b want 100", {tAck, tWeo, tWer}); end
    bus_xfer(1'b0, 3'd6, 32'h0, i_DIN, tAck, tRd, tWeo, tWer, tDd);
    total++; if (tAck !== 1'b1) begin bad++; $display("[TB] FAIL unmapped6_ack: got %b want 1", tAck); end
    total++; if (tRd !== 32'h0) begin bad++; $display("[TB] FAIL unmapped6_read: got %h want 0", tRd); end
    bus_xfer(1'b0, 3'd7, 32'h0, i_DIN, tAck, tRd, tWeo, tWer, tDd);
    total++; if (tRd !== 32'h0) begin bad++; $display("[TB] FAIL unmapped7_read: got %h want 0", tRd); end
    // DATA_IN returns the pins as seen in the capture cycle, not the ACK cycle
    @(negedge i_Clk);
    i_DIN = 32'h1234_5678;
    bus_xfer(1'b0, 3'd2, 32'h0, 32'h0, tAck, tRd, tWeo, tWer, tDd);
    total++; if (tRd !== 32'h1234_5678) begin bad++; $display("[TB] FAIL din_read: got %h want 12345678", tRd); end
  endtask

  task automatic test_edge_irq();
    bus_xfer(1'b1, 3'd1, 32'h1, 32'h0, tAck, tRd, tWeo, tWer, tDd);
    bus_xfer(1'b1, 3'd3, 32'h1, 32'h0, tAck, tRd, tWeo, tWer, tDd);
    bus_xfer(1'b1, 3'd4, 32'h1, 32'h0, tAck, tRd, tWeo, tWer, tDd);
    bus_xfer(1'b0, 3'd4, 32'h0, 32'h0, tAck, tRd, tWeo, tWer, tDd);
    total++; if (tRd !== 32'h1) begin bad++; $display("[TB] FAIL irise_read: got %h want 1", tRd); end
    @(negedge i_Clk);
    i_DIN = 32'h1;
    @(posedge i_Clk); #1;
    total++; if (o_Irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_not_early: got %b want 0", o_Irq); end
    @(posedge i_Clk); #1;
    total++; if (o_Irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_rise: got %b want 1", o_Irq); end
    bus_xfer(1'b0, 3'd5, 32'h0, 32'h1, tAck, tRd, tWeo, tWer, tDd);
    total++; if (tRd !== 32'h1) begin bad++; $display("[TB] FAIL pend_rise: got %h want 1", tRd); end
    bus_xfer(1'b1, 3'd5, 32'h1, 32'h1, tAck, tRd, tWeo, tWer, tDd);
    @(posedge i_Clk); #1;
    total++; if (o_Irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_after_clear: got %b want 0", o_Irq); end
    @(negedge i_Clk);
    i_DIN = 32'h0;
    repeat (2) @(posedge i_Clk);
    #1;
    total++; if (o_Irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_fall_ignored: got %b want 0", o_Irq); end
    bus_xfer(1'b0, 3'd5, 32'h0, 32'h0, tAck, tRd, tWeo, tWer, tDd);
    total++; if (tRd !== 32'h0) begin bad++; $display("[TB] FAIL pend_fall_ignored: got %h want 0", tRd); end
  endtask

  task automatic test_pend_clear();
    @(negedge i_Clk);
    i_DIN = 32'h1;
    @(negedge i_Clk);
    i_DIN = 32'h0;
    @(posedge i_Clk); #1;
    // Clear bit 0 while a new rising edge arrives in the ACK cycle
    bus_xfer(1'b1, 3'd5, 32'h1, 32'h1, tAck, tRd, tWeo, tWer, tDd);
    bus_xfer(1'b0, 3'd5, 32'h0, 32'h1, tAck, tRd, tWeo, tWer, tDd);
    total++; if (tRd !== 32'h1) begin bad++; $display("[TB] FAIL set_wins: got %h want 1", tRd); end
    total++; if (o_Irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_set_wins: got %b want 1", o_Irq); end
    bus_xfer(1'b1, 3'd5, 32'h1, 32'h1, tAck, tRd, tWeo, tWer, tDd);
    total++; if (o_Irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_hold_one: got %b want 1", o_Irq); end
    @(posedge i_Clk); #1;
    total++; if (o_Irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_drop: got %b want 0", o_Irq); end
    bus_xfer(1'b0, 3'd5, 32'h0, 32'h1, tAck, tRd, tWeo, tWer, tDd);
    total++; if (tRd !== 32'h0) begin bad++; $display("[TB] FAIL pend_cleared: got %h want 0", tRd); end
  endtask

  task automatic test_output_pins();
    bus_xfer(1'b1, 3'd1, 32'h0, i_DIN, tAck, tRd, tWeo, tWer, tDd);
    bus_xfer(1'b1, 3'd3, 32'hFFFF_FFFF, i_DIN, tAck, tRd, tWeo, tWer, tDd);
    for (int k = 0; k < 6; k++) begin
      @(negedge i_Clk);
      i_DIN = ~i_DIN;
      @(posedge i_Clk); #1;
      total++; if (o_Irq !== 1'b0) begin bad++; $display("[TB] FAIL outpin_irq_%0d: got %b want 0", k, o_Irq); end
    end
    bus_xfer(1'b0, 3'd5, 32'h0, i_DIN, tAck, tRd, tWeo, tWer, tDd);
    total++; if (tRd !== 32'h0) begin bad++; $display("[TB] FAIL outpin_pend: got %h want 0", tRd); end
  endtask

  task automatic test_back_to_back();
    int acks;
    logic expAck;
    acks = 0;
    @(negedge i_Clk);
    i_Req   = 1'b1;
    i_We    = 1'b1;
    i_Addr  = 3'd0;
    i_WData = 32'h0F0F_0F0F;
    for (int c = 0; c < 6; c++) begin
      @(posedge i_Clk); #1;
      expAck = ((c % 2) == 0);
      total++; if (o_Ack !== expAck) begin bad++; $display("[TB] FAIL b2b_ack_%0d: got %b want %b", c, o_Ack, expAck); end
      if (o_Ack === 1'b1) acks++;
    end
    i_Req = 1'b0;
    total++; if (acks != 3) begin bad++; $display("[TB] FAIL b2b_count: got %0d want 3", acks); end
    bus_xfer(1'b0, 3'd0, 32'h0, i_DIN, tAck, tRd, tWeo, tWer, tDd);
    total++; if (tRd !== 32'h0F0F_0F0F) begin bad++; $display("[TB] FAIL b2b_dout: got %h want 0f0f0f0f", tRd); end
  endtask

  task automatic test_reset_abort();
    bus_xfer(1'b1, 3'd1, 32'h1, 32'h0, tAck, tRd, tWeo, tWer, tDd);
    bus_xfer(1'b1, 3'd3, 32'h1, 32'h0, tAck, tRd, tWeo, tWer, tDd);
    @(negedge i_Clk);
    i_DIN = 32'h1;
    repeat (2) @(posedge i_Clk);
    #1;
    total++; if (o_Irq !== 1'b1) begin bad++; $display("[TB] FAIL abort_setup_irq: got %b want 1", o_Irq); end
    @(negedge i_Clk);
    i_Req   = 1'b1;
    i_We    = 1'b1;
    i_Addr  = 3'd1;
    i_WData = 32'h0000_1234;
    i_rst   = 1'b1;
    @(posedge i_Clk); #1;
    total++; if ({o_Ack, o_WEO, o_WER} !== 3'b000) begin bad++; $display("[TB] FAIL abort_cycle: got %b want 000", {o_Ack, o_WEO, o_WER}); end
    total++; if (o_Irq !== 1'b0) begin bad++; $display("[TB] FAIL abort_irq: got %b want 0", o_Irq); end
    total++; if (o_DD !== 32'h0) begin bad++; $display("[TB] FAIL abort_dd: got %h want 0", o_DD); end
    i_rst = 1'b0;
    i_Req = 1'b0;
    @(posedge i_Clk); #1;
    total++; if ({o_Ack, o_WEO, o_WER} !== 3'b000) begin bad++; $display("[TB] FAIL abort_next: got %b want 000", {o_Ack, o_WEO, o_WER}); end
    bus_xfer(1'b0, 3'd1, 32'h0, i_DIN, tAck, tRd, tWeo, tWer, tDd);
    total++; if (tRd !== 32'h0) begin bad++; $display("[TB] FAIL abort_dir: got %h want 0", tRd); end
    bus_xfer(1'b0, 3'd0, 32'h0, i_DIN, tAck, tRd, tWeo, tWer, tDd);
    total++; if (tRd !== 32'h0) begin bad++; $display("[TB] FAIL abort_dout: got %h want 0", tRd); end
    bus_xfer(1'b0, 3'd3, 32'h0, i_DIN, tAck, tRd, tWeo, tWer, tDd);
    total++; if (tRd !== 32'h0) begin bad++; $display("[TB] FAIL abort_ien: got %h want 0", tRd); end
    bus_xfer(1'b0, 3'd4, 32'h0, i_DIN, tAck, tRd, tWeo, tWer, tDd);
    total++; if (tRd !== 32'h0) begin bad++; $display("[TB] FAIL abort_irise: got %h want 0", tRd); end
    bus_xfer(1'b0, 3'd5, 32'h0, i_DIN, tAck, tRd, tWeo, tWer, tDd);
    total++; if (tRd !== 32'h0) begin bad++; $display("[TB] FAIL abort_pend: got %h want 0", tRd); end
  endtask

  // Scenario sequence
  initial begin
    i_rst   = 1'b1;
    i_Req   = 1'b0;
    i_We    = 1'b0;
    i_Addr  = 3'd0;
    i_WData = 32'h0;
    i_DIN   = 32'h0;
    test_reset();
    test_dir_write();
    test_data_out();
    test_edge_irq();
    test_pend_clear();
    test_output_pins();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
